// File: rtl/multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_pkg
// Shared definitions for the multi-cycle RV32 controller: opcode constants,
// datapath select encodings, the FSM state encoding and the control bundle
// produced by the output decoder.
// ---------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    // Opcodes (IR[6:0])
    localparam logic [6:0] OpcLw    = 7'b0000011;
    localparam logic [6:0] OpcSw    = 7'b0100011;
    localparam logic [6:0] OpcFsw   = 7'b0100111;
    localparam logic [6:0] OpcAddi  = 7'b0010011;
    localparam logic [6:0] OpcAdd   = 7'b0110011;
    localparam logic [6:0] OpcBeq   = 7'b1100011;
    localparam logic [6:0] OpcJal   = 7'b1101111;
    localparam logic [6:0] OpcRfsop = 7'b1010011;

    localparam logic Yes = 1'b1;
    localparam logic No  = 1'b0;

    // ALU operation
    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    // Register write-back source
    localparam logic [1:0] RegSrcAluOut = 2'b00;
    localparam logic [1:0] RegSrcMdr    = 2'b01;
    localparam logic [1:0] RegSrcPc     = 2'b10;

    // PC source
    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;

    // ALU operand selects
    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcARs1   = 2'b01;
    localparam logic [1:0] SrcAOldPc = 2'b10;
    localparam logic [1:0] SrcBRs2   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRd   = 4'd3,
        StWbMem   = 4'd4,
        StMemWr   = 4'd5,
        StExec    = 4'd6,
        StWbAlu   = 4'd7,
        StBranch  = 4'd8,
        StJal     = 4'd9,
        StFpStart = 4'd10,
        StFpWait  = 4'd11,
        StFpWb    = 4'd12,
        StHalt    = 4'd13
    } state_e;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] reg_src;
        logic       freg_write;
        logic       flt;
        logic       fpu_start;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_fp_watchdog.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fp_watchdog
// Counts cycles spent waiting on the FPU and raises a sticky error when the
// wait reaches FP_TIMEOUT cycles without a result.
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   clr_i      restart the count (FPU launch)
//   en_i       count this cycle (waiting on FPU)
//   done_i     FPU result arrives this cycle; suppresses the timeout
//   expired_o  last allowed wait cycle passed without a result
//   err_o      sticky timeout flag
// ---------------------------------------------------------------------------
module multicycle_ctrl_fp_watchdog #(
    parameter int unsigned FP_TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    input  logic done_i,
    output logic expired_o,
    output logic err_o
);

    // One spare bit so the count never wraps even if it steps past the limit.
    localparam int unsigned CntW = $clog2(FP_TIMEOUT) + 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    always_comb begin
        expired_o = en_i && !done_i && (cnt_q == CntW'(FP_TIMEOUT - 1));
        cnt_d     = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CntW'(1);
        end
        err_d = err_q | expired_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Moore controller for a shared multi-cycle RV32 datapath (single ALU, unified
// memory port, integer/FP register files, external multi-cycle FPU). Also
// counts retired instructions and watches the FPU for hangs.
//   clk, rst        clock, synchronous active-high reset
//   opcode          IR[6:0]
//   mem_ready       memory completes the current request
//   fpu_done        FPU result valid pulse
//   mem_req..float  datapath strobes and selects
//   fpu_start       one-cycle FPU launch
//   halted          sticky halt (illegal opcode or FPU timeout)
//   fp_timeout_err  sticky FPU watchdog error
//   instret         retired-instruction count
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned FP_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    input  logic             fpu_done,
    output logic             mem_req,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUop,
    output logic             RegWrite,
    output logic [1:0]       RegSrc,
    output logic             FRegWrite,
    output logic             float,
    output logic             fpu_start,
    output logic             halted,
    output logic             fp_timeout_err,
    output logic [CNT_W-1:0] instret
);

    state_e           state_q, state_d;
    ctrl_t            ctl;
    logic             retire;
    logic             wd_clr, wd_en, wd_expired;
    logic [CNT_W-1:0] instret_q, instret_d;

    multicycle_ctrl_fp_watchdog #(
        .FP_TIMEOUT (FP_TIMEOUT)
    ) u_fp_watchdog (
        .clk_i     (clk),
        .rst_i     (rst),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .done_i    (fpu_done),
        .expired_o (wd_expired),
        .err_o     (fp_timeout_err)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:   if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OpcLw, OpcSw, OpcFsw: state_d = StMemAddr;
                    OpcAdd, OpcAddi:      state_d = StExec;
                    OpcBeq:               state_d = StBranch;
                    OpcJal:               state_d = StJal;
                    OpcRfsop:             state_d = StFpStart;
                    default:              state_d = StHalt;
                endcase
            end
            StMemAddr: state_d = (opcode == OpcLw) ? StMemRd : StMemWr;
            StMemRd:   if (mem_ready) state_d = StWbMem;
            StMemWr:   if (mem_ready) state_d = StFetch;
            StExec:    state_d = StWbAlu;
            StFpStart: state_d = StFpWait;
            StFpWait: begin
                // A result in the final wait cycle beats the timeout.
                if (fpu_done) begin
                    state_d = StFpWb;
                end else if (wd_expired) begin
                    state_d = StHalt;
                end
            end
            StWbMem, StWbAlu, StBranch, StJal, StFpWb: state_d = StFetch;
            StHalt:    state_d = StHalt;
            default:   state_d = StHalt;
        endcase
    end

    // Output decode; everything reads 0 while reset is asserted.
    always_comb begin
        ctl    = '0;
        retire = No;
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    ctl.mem_req = Yes;
                    if (mem_ready) begin
                        ctl.ir_write  = Yes;
                        ctl.pc_write  = Yes;
                        ctl.alu_src_a = SrcAPc;
                        ctl.alu_src_b = SrcBFour;
                        ctl.alu_op    = AluOpAdd;
                        ctl.pc_source = PcSrcAlu;
                    end
                end
                StDecode: begin
                    ctl.alu_src_a = SrcAOldPc;
                    ctl.alu_src_b = SrcBImm;
                    ctl.alu_op    = AluOpAdd;
                end
                StMemAddr: begin
                    ctl.alu_src_a = SrcARs1;
                    ctl.alu_src_b = SrcBImm;
                    ctl.alu_op    = AluOpAdd;
                end
                StMemRd: begin
                    ctl.mem_req = Yes;
                    ctl.iord    = Yes;
                end
                StWbMem: begin
                    ctl.reg_write = Yes;
                    ctl.reg_src   = RegSrcMdr;
                    retire        = Yes;
                end
                StMemWr: begin
                    ctl.mem_req   = Yes;
                    ctl.mem_write = Yes;
                    ctl.iord      = Yes;
                    ctl.flt       = (opcode == OpcFsw);
                    retire        = mem_ready;
                end
                StExec: begin
                    ctl.alu_src_a = SrcARs1;
                    if (opcode == OpcAdd) begin
                        ctl.alu_src_b = SrcBRs2;
                        ctl.alu_op    = AluOpFunct;
                    end else begin
                        ctl.alu_src_b = SrcBImm;
                        ctl.alu_op    = AluOpAdd;
                    end
                end
                StWbAlu: begin
                    ctl.reg_write = Yes;
                    ctl.reg_src   = RegSrcAluOut;
                    retire        = Yes;
                end
                StBranch: begin
                    ctl.alu_src_a     = SrcARs1;
                    ctl.alu_src_b     = SrcBRs2;
                    ctl.alu_op        = AluOpSub;
                    ctl.pc_write_cond = Yes;
                    ctl.pc_source     = PcSrcAluOut;
                    retire            = Yes;
                end
                StJal: begin
                    // PC already holds PC+4 from fetch, so it is the link value.
                    ctl.pc_write  = Yes;
                    ctl.pc_source = PcSrcAluOut;
                    ctl.reg_write = Yes;
                    ctl.reg_src   = RegSrcPc;
                    retire        = Yes;
                end
                StFpStart: ctl.fpu_start = Yes;
                StFpWb: begin
                    ctl.freg_write = Yes;
                    retire         = Yes;
                end
                StHalt:  ctl.halted = Yes;
                default: ;
            endcase
        end
    end

    assign wd_clr = (state_q == StFpStart);
    assign wd_en  = (state_q == StFpWait);

    // Retired-instruction counter; wraps silently.
    assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign mem_req     = ctl.mem_req;
    assign IorD        = ctl.iord;
    assign MemWrite    = ctl.mem_write;
    assign IRWrite     = ctl.ir_write;
    assign PCWrite     = ctl.pc_write;
    assign PCWriteCond = ctl.pc_write_cond;
    assign PCSource    = ctl.pc_source;
    assign ALUSrcA     = ctl.alu_src_a;
    assign ALUSrcB     = ctl.alu_src_b;
    assign ALUop       = ctl.alu_op;
    assign RegWrite    = ctl.reg_write;
    assign RegSrc      = ctl.reg_src;
    assign FRegWrite   = ctl.freg_write;
    assign float       = ctl.flt;
    assign fpu_start   = ctl.fpu_start;
    assign halted      = ctl.halted;
    assign instret     = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle control-word checks against
// hand-written expectations, plus pulse counters and instret checks.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] reg_src;
        logic       freg_write;
        logic       flt;
        logic       fpu_start;
        logic       halted;
        logic       fp_err;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst, mem_ready, fpu_done;
    logic [6:0]  opcode;
    logic        mem_req, IorD, MemWrite, IRWrite, PCWrite, PCWriteCond;
    logic [1:0]  PCSource, ALUSrcA, ALUSrcB, ALUop, RegSrc;
    logic        RegWrite, FRegWrite, float, fpu_start, halted, fp_timeout_err;
    logic [31:0] instret;
    ctl_t        obs;

    int n_chk = 0;
    int n_err = 0;
    int n_irw = 0, n_fst = 0, n_frw = 0, n_rw = 0, n_cyc = 0;
    int snap_irw, snap_fst, snap_frw, snap_rw, snap_cyc;
    logic [31:0] exp_ir;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .CNT_W      (32),
        .FP_TIMEOUT (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .opcode         (opcode),
        .mem_ready      (mem_ready),
        .fpu_done       (fpu_done),
        .mem_req        (mem_req),
        .IorD           (IorD),
        .MemWrite       (MemWrite),
        .IRWrite        (IRWrite),
        .PCWrite        (PCWrite),
        .PCWriteCond    (PCWriteCond),
        .PCSource       (PCSource),
        .ALUSrcA        (ALUSrcA),
        .ALUSrcB        (ALUSrcB),
        .ALUop          (ALUop),
        .RegWrite       (RegWrite),
        .RegSrc         (RegSrc),
        .FRegWrite      (FRegWrite),
        .float          (float),
        .fpu_start      (fpu_start),
        .halted         (halted),
        .fp_timeout_err (fp_timeout_err),
        .instret        (instret)
    );

    assign obs = {mem_req, IorD, MemWrite, IRWrite, PCWrite, PCWriteCond, PCSource, ALUSrcA,
                  ALUSrcB, ALUop, RegWrite, RegSrc, FRegWrite, float, fpu_start, halted,
                  fp_timeout_err};

    // Pulse counters sample the previous cycle's settled outputs.
    always @(posedge clk) begin
        n_cyc <= n_cyc + 1;
        if (IRWrite)   n_irw <= n_irw + 1;
        if (fpu_start) n_fst <= n_fst + 1;
        if (FRegWrite) n_frw <= n_frw + 1;
        if (RegWrite)  n_rw  <= n_rw + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Inputs are set by the caller just after an edge; settle, compare, move on.
    task automatic exp_cyc(input string tag, input ctl_t e);
        #1;
        check_val(tag, {10'd0, obs}, {10'd0, e});
        @(posedge clk);
        #1;
    endtask

    function automatic ctl_t f_fetch(input logic rdy);
        ctl_t e = '0;
        e.mem_req = 1'b1;
        if (rdy) begin
            e.ir_write  = 1'b1;
            e.pc_write  = 1'b1;
            e.alu_src_b = 2'b01;
        end
        return e;
    endfunction

    function automatic ctl_t f_decode();
        ctl_t e = '0;
        e.alu_src_a = 2'b10;
        e.alu_src_b = 2'b10;
        return e;
    endfunction

    function automatic ctl_t f_memaddr();
        ctl_t e = '0;
        e.alu_src_a = 2'b01;
        e.alu_src_b = 2'b10;
        return e;
    endfunction

    function automatic ctl_t f_memrd();
        ctl_t e = '0;
        e.mem_req = 1'b1;
        e.iord    = 1'b1;
        return e;
    endfunction

    function automatic ctl_t f_wbmem();
        ctl_t e = '0;
        e.reg_write = 1'b1;
        e.reg_src   = 2'b01;
        return e;
    endfunction

    function automatic ctl_t f_memwr(input logic fl);
        ctl_t e = '0;
        e.mem_req   = 1'b1;
        e.iord      = 1'b1;
        e.mem_write = 1'b1;
        e.flt       = fl;
        return e;
    endfunction

    function automatic ctl_t f_exec(input logic is_add);
        ctl_t e = '0;
        e.alu_src_a = 2'b01;
        e.alu_src_b = is_add ? 2'b00 : 2'b10;
        e.alu_op    = is_add ? 2'b10 : 2'b00;
        return e;
    endfunction

    function automatic ctl_t f_wbalu();
        ctl_t e = '0;
        e.reg_write = 1'b1;
        return e;
    endfunction

    function automatic ctl_t f_branch();
        ctl_t e = '0;
        e.alu_src_a     = 2'b01;
        e.alu_op        = 2'b01;
        e.pc_write_cond = 1'b1;
        e.pc_source     = 2'b01;
        return e;
    endfunction

    function automatic ctl_t f_jal();
        ctl_t e = '0;
        e.pc_write  = 1'b1;
        e.pc_source = 2'b01;
        e.reg_write = 1'b1;
        e.reg_src   = 2'b10;
        return e;
    endfunction

    function automatic ctl_t f_one(input int which);
        ctl_t e = '0;
        case (which)
            0: e.fpu_start  = 1'b1;
            1: e.freg_write = 1'b1;
            2: e.halted     = 1'b1;
            3: begin e.halted = 1'b1; e.fp_err = 1'b1; end
            4: e.fp_err     = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic fetch_decode(input string tag);
        mem_ready = 1'b1;
        exp_cyc({tag, " fetch"}, f_fetch(1'b1));
        mem_ready = 1'b0;
        exp_cyc({tag, " decode"}, f_decode());
    endtask

    task automatic snap();
        snap_irw = n_irw; snap_fst = n_fst; snap_frw = n_frw; snap_rw = n_rw; snap_cyc = n_cyc;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; mem_ready = 1'b0; fpu_done = 1'b0; opcode = 7'h00;
        @(posedge clk); @(posedge clk); #1;
        exp_cyc("rst hold", '0);
        rst = 1'b0;
        check_val("rst instret", instret, 32'd0);
        exp_cyc("post rst fetch", f_fetch(1'b0));

        // add, zero-wait memory
        opcode = 7'h33; snap();
        fetch_decode("add");
        exp_cyc("add exec", f_exec(1'b1));
        exp_cyc("add wb", f_wbalu());
        check_val("add cycles", n_cyc - snap_cyc, 4);
        check_val("add regwrite", n_rw - snap_rw, 1);
        check_val("add instret", instret, 32'd1);

        // reset held in MEMRD with an outstanding read
        opcode = 7'h03;
        fetch_decode("rstlw");
        exp_cyc("rstlw memaddr", f_memaddr());
        rst = 1'b1;
        for (int i = 0; i < 3; i++) exp_cyc("rst in memrd", '0);
        rst = 1'b0;
        #1;
        check_val("rst memrd instret", instret, 32'd0);
        exp_cyc("rst memrd fetch", f_fetch(1'b0));
        exp_ir = 32'd0;

        // lw with wait states
        opcode = 7'h03; snap();
        for (int i = 0; i < 3; i++) exp_cyc("lw fetch wait", f_fetch(1'b0));
        fetch_decode("lw");
        exp_cyc("lw memaddr", f_memaddr());
        for (int i = 0; i < 2; i++) exp_cyc("lw memrd wait", f_memrd());
        mem_ready = 1'b1;
        exp_cyc("lw memrd", f_memrd());
        mem_ready = 1'b0;
        exp_cyc("lw wb", f_wbmem());
        exp_ir++;
        check_val("lw cycles", n_cyc - snap_cyc, 10);
        check_val("lw irwrite", n_irw - snap_irw, 1);
        check_val("lw instret", instret, exp_ir);

        // fsw with one store wait
        opcode = 7'h27; snap();
        fetch_decode("fsw");
        exp_cyc("fsw memaddr", f_memaddr());
        exp_cyc("fsw memwr wait", f_memwr(1'b1));
        check_val("fsw no early retire", instret, exp_ir);
        mem_ready = 1'b1;
        exp_cyc("fsw memwr", f_memwr(1'b1));
        mem_ready = 1'b0;
        exp_ir++;
        check_val("fsw instret", instret, exp_ir);
        check_val("fsw regwrite", (n_rw - snap_rw) + (n_frw - snap_frw), 0);
        exp_cyc("fsw next fetch", f_fetch(1'b0));

        // sw: float stays low
        opcode = 7'h23;
        fetch_decode("sw");
        exp_cyc("sw memaddr", f_memaddr());
        mem_ready = 1'b1;
        exp_cyc("sw memwr", f_memwr(1'b0));
        mem_ready = 1'b0;
        exp_ir++;

        // FP op, result after 5 wait cycles
        opcode = 7'h53; snap();
        fetch_decode("fp");
        exp_cyc("fp start", f_one(0));
        for (int i = 0; i < 4; i++) exp_cyc("fp wait", '0);
        fpu_done = 1'b1;
        exp_cyc("fp wait done", '0);
        fpu_done = 1'b0;
        exp_cyc("fp wb", f_one(1));
        exp_ir++;
        check_val("fp start pulses", n_fst - snap_fst, 1);
        check_val("fp fregwrite", n_frw - snap_frw, 1);
        check_val("fp instret", instret, exp_ir);

        // FP result on the final allowed cycle beats the timeout
        fetch_decode("fp64");
        exp_cyc("fp64 start", f_one(0));
        for (int i = 0; i < 63; i++) exp_cyc("fp64 wait", '0);
        fpu_done = 1'b1;
        exp_cyc("fp64 last wait", '0);
        fpu_done = 1'b0;
        exp_cyc("fp64 wb", f_one(1));
        exp_ir++;
        exp_cyc("fp64 fetch no err", f_fetch(1'b0));

        // FP timeout
        fetch_decode("fpto");
        exp_cyc("fpto start", f_one(0));
        for (int i = 0; i < 64; i++) exp_cyc("fpto wait", '0);
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b1; fpu_done = (i == 1);
            exp_cyc("fpto halted", f_one(3));
        end
        mem_ready = 1'b0; fpu_done = 1'b0;
        check_val("fpto instret", instret, exp_ir);
        rst = 1'b1;
        exp_cyc("fpto rst", f_one(4));
        rst = 1'b0;
        exp_ir = 32'd0;
        check_val("fpto rst instret", instret, exp_ir);
        exp_cyc("fpto rst fetch", f_fetch(1'b0));

        // beq, jal, addi
        opcode = 7'h63; snap();
        fetch_decode("beq");
        exp_cyc("beq branch", f_branch());
        exp_ir++;
        check_val("beq cycles", n_cyc - snap_cyc, 3);
        opcode = 7'h6F;
        fetch_decode("jal");
        exp_cyc("jal", f_jal());
        exp_ir++;
        opcode = 7'h13;
        fetch_decode("addi");
        exp_cyc("addi exec", f_exec(1'b0));
        exp_cyc("addi wb", f_wbalu());
        exp_ir++;
        check_val("addi instret", instret, exp_ir);

        // illegal opcode halts until reset
        opcode = 7'h7F;
        fetch_decode("ill");
        for (int i = 0; i < 100; i++) begin
            mem_ready = i[0]; fpu_done = i[1];
            exp_cyc("ill halted", f_one(2));
        end
        mem_ready = 1'b0; fpu_done = 1'b0;
        check_val("ill instret frozen", instret, exp_ir);
        rst = 1'b1;
        exp_cyc("ill rst", '0);
        rst = 1'b0;
        check_val("ill rst instret", instret, 32'd0);
        exp_cyc("ill rst fetch", f_fetch(1'b0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
